// File: rtl/crc32_galois_pkg.sv
// crc32_galois_pkg: shared CRC32 Galois constants, FSM states and 65-bit next-state function.
package crc32_galois_pkg;

    localparam logic [31:0] CRC32_POLY = 32'h00A00805;
    localparam logic [31:0] CRC32_SEED = 32'h0;

    typedef enum logic [1:0] {IDLE, ACCUM, DROP} state_t;

    // DIN[64] enters first, DIN[0] last; the loop unrolls to the parallel equations
    function automatic logic [31:0] crc32_d65_next(input logic [31:0] crc, input logic [64:0] din);
        logic [31:0] c;
        c = crc;
        for (int i = 64; i >= 0; i--)
            c = {c[30:0], 1'b0} ^ ((c[31] ^ din[i]) ? CRC32_POLY : 32'h0);
        return c;
    endfunction

endpackage

// File: rtl/crc32_sat_cnt.sv
// crc32_sat_cnt: saturating counter with synchronous clear taking priority over increment.
module crc32_sat_cnt #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) q <= '0;
        else q <= clr ? '0 : (inc && q != '1) ? q + W'(1) : q;

endmodule

// File: rtl/crc32_galois_d65_chk.sv
// crc32_galois_d65_chk: receive-side CRC32 checker for 65-bit framed words with
// per-frame verdict and saturating good/bad/framing statistics.
module crc32_galois_d65_chk
    import crc32_galois_pkg::*;
#(
    parameter int MAX_WORDS = 256,
    parameter int CNT_W     = 16,
    parameter int LEN_W     = 9
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VLD,
    input  logic             IN_SOF,
    input  logic             IN_EOF,
    input  logic [64:0]      DIN,
    input  logic             CNT_CLR,
    output logic             RES_VLD,
    output logic             RES_PASS,
    output logic [LEN_W-1:0] RES_LEN,
    output logic [31:0]      RES_CRC,
    output logic [CNT_W-1:0] CNT_GOOD,
    output logic [CNT_W-1:0] CNT_BAD,
    output logic [CNT_W-1:0] CNT_FRM
);

    state_t st, st_n;
    logic [31:0] acc, acc_n, vcrc;
    logic [LEN_W-1:0] len, len_n, vlen;
    logic v_n, frm_inc, pass_n;

    assign pass_n = vcrc == DIN[31:0];

    // SOF restarts from any state; an SOF inside a frame also counts as a framing error
    always_comb begin
        st_n = st;
        acc_n = acc;
        len_n = len;
        v_n = 1'b0;
        vcrc = acc;
        vlen = len;
        frm_inc = 1'b0;
        if (IN_VLD && IN_SOF) begin
            frm_inc = st == ACCUM;
            st_n = IN_EOF ? IDLE : ACCUM;
            acc_n = IN_EOF ? CRC32_SEED : crc32_d65_next(CRC32_SEED, DIN);
            len_n = IN_EOF ? '0 : LEN_W'(1);
            v_n = IN_EOF;
            vcrc = CRC32_SEED;
            vlen = '0;
        end else if (IN_VLD && st == IDLE) begin
            frm_inc = IN_EOF;
        end else if (IN_VLD && st == ACCUM && IN_EOF) begin
            v_n = 1'b1;
            st_n = IDLE;
            acc_n = CRC32_SEED;
            len_n = '0;
        end else if (IN_VLD && st == ACCUM && len == LEN_W'(MAX_WORDS)) begin
            frm_inc = 1'b1;
            st_n = DROP;
        end else if (IN_VLD && st == ACCUM) begin
            acc_n = crc32_d65_next(acc, DIN);
            len_n = len + LEN_W'(1);
        end else if (IN_VLD && IN_EOF) begin
            st_n = IDLE;
        end
    end

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            st <= IDLE;
            acc <= CRC32_SEED;
            len <= '0;
            RES_VLD <= 1'b0;
            RES_PASS <= 1'b0;
            RES_LEN <= '0;
            RES_CRC <= '0;
        end else begin
            st <= st_n;
            acc <= acc_n;
            len <= len_n;
            RES_VLD <= v_n;
            if (v_n) begin
                RES_PASS <= pass_n;
                RES_LEN <= vlen;
                RES_CRC <= vcrc;
            end
        end

    crc32_sat_cnt #(.W(CNT_W)) u_good (.CLK(CLK), .RST_N(RST_N), .clr(CNT_CLR), .inc(v_n && pass_n), .q(CNT_GOOD));
    crc32_sat_cnt #(.W(CNT_W)) u_bad (.CLK(CLK), .RST_N(RST_N), .clr(CNT_CLR), .inc(v_n && !pass_n), .q(CNT_BAD));
    crc32_sat_cnt #(.W(CNT_W)) u_frm (.CLK(CLK), .RST_N(RST_N), .clr(CNT_CLR), .inc(frm_inc), .q(CNT_FRM));

endmodule

// File: tb/tb_crc32_galois_d65_chk.sv
// tb_crc32_galois_d65_chk: directed checks of the CRC checker; instance b uses
// MAX_WORDS=4 and 3-bit counters to reach overflow and saturation quickly.
module tb_crc32_galois_d65_chk;

    logic CLK = 1'b0, RST_N = 1'b0;
    logic IN_VLD = 1'b0, IN_SOF = 1'b0, IN_EOF = 1'b0, CNT_CLR = 1'b0;
    logic [64:0] DIN = '0;
    logic a_vld, a_pass, b_vld, b_pass;
    logic [8:0] a_len, b_len;
    logic [31:0] a_crc, b_crc;
    logic [15:0] a_good, a_bad, a_frm;
    logic [2:0] b_good, b_bad, b_frm;
    int total = 0, bad = 0;

    always #5 CLK = ~CLK;

    crc32_galois_d65_chk dut_a (
        .CLK(CLK), .RST_N(RST_N), .IN_VLD(IN_VLD), .IN_SOF(IN_SOF), .IN_EOF(IN_EOF),
        .DIN(DIN), .CNT_CLR(CNT_CLR), .RES_VLD(a_vld), .RES_PASS(a_pass), .RES_LEN(a_len),
        .RES_CRC(a_crc), .CNT_GOOD(a_good), .CNT_BAD(a_bad), .CNT_FRM(a_frm)
    );

    crc32_galois_d65_chk #(.MAX_WORDS(4), .CNT_W(3), .LEN_W(9)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .IN_VLD(IN_VLD), .IN_SOF(IN_SOF), .IN_EOF(IN_EOF),
        .DIN(DIN), .CNT_CLR(CNT_CLR), .RES_VLD(b_vld), .RES_PASS(b_pass), .RES_LEN(b_len),
        .RES_CRC(b_crc), .CNT_GOOD(b_good), .CNT_BAD(b_bad), .CNT_FRM(b_frm)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wd(input logic s, input logic e, input logic [64:0] d);
        IN_VLD = 1'b1;
        IN_SOF = s;
        IN_EOF = e;
        DIN = d;
        @(posedge CLK);
        #1;
        IN_VLD = 1'b0;
        IN_SOF = 1'b0;
        IN_EOF = 1'b0;
    endtask

    task automatic stall(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic verdict_a(input string tag, input logic p, input logic [8:0] l, input logic [31:0] c);
        chk({tag, "_vld"}, 64'(a_vld), 64'd1);
        chk({tag, "_pass"}, 64'(a_pass), 64'(p));
        chk({tag, "_len"}, 64'(a_len), 64'(l));
        chk({tag, "_crc"}, 64'(a_crc), 64'(c));
    endtask

    initial begin
        stall(2);
        chk("rst_vld", 64'(a_vld), 64'd0);
        chk("rst_crc", 64'(a_crc), 64'd0);
        chk("rst_good", 64'(a_good), 64'd0);
        chk("rst_frm", 64'(a_frm), 64'd0);
        RST_N = 1'b1;
        stall(1);
        wd(1'b1, 1'b0, 65'h0);
        chk("t1_novld", 64'(a_vld), 64'd0);
        wd(1'b0, 1'b1, 65'h0);
        verdict_a("t1", 1'b1, 9'd1, 32'h0);
        chk("t1_good", 64'(a_good), 64'd1);
        stall(1);
        chk("t1_pulse", 64'(a_vld), 64'd0);
        wd(1'b1, 1'b0, 65'h1);
        wd(1'b0, 1'b1, 65'h00A00805);
        verdict_a("t2", 1'b1, 9'd1, 32'h00A00805);
        wd(1'b1, 1'b0, 65'h1);
        wd(1'b0, 1'b1, 65'h00A00804);
        verdict_a("t3", 1'b0, 9'd1, 32'h00A00805);
        chk("t3_bad", 64'(a_bad), 64'd1);
        chk("t3_good", 64'(a_good), 64'd2);
        wd(1'b1, 1'b0, {1'b1, 64'h0});
        stall(5);
        chk("t4_stall", 64'(a_vld), 64'd0);
        wd(1'b0, 1'b1, 65'h30201181);
        verdict_a("t4", 1'b1, 9'd1, 32'h30201181);
        wd(1'b1, 1'b0, 65'h1);
        wd(1'b0, 1'b0, 65'h0);
        wd(1'b0, 1'b1, 65'h60402302);
        verdict_a("t5", 1'b1, 9'd2, 32'h60402302);
        chk("t5_good", 64'(a_good), 64'd4);
        wd(1'b1, 1'b0, 65'h55);
        wd(1'b1, 1'b0, 65'h1);
        chk("t6_abort_frm", 64'(a_frm), 64'd1);
        chk("t6_abort_novld", 64'(a_vld), 64'd0);
        wd(1'b0, 1'b1, 65'h00A00805);
        verdict_a("t6", 1'b1, 9'd1, 32'h00A00805);
        wd(1'b0, 1'b1, 65'h0);
        chk("t6_lone_novld", 64'(a_vld), 64'd0);
        chk("t6_lone_frm", 64'(a_frm), 64'd2);
        chk("t6_good", 64'(a_good), 64'd5);
        wd(1'b1, 1'b1, 65'h0);
        verdict_a("t7a", 1'b1, 9'd0, 32'h0);
        wd(1'b1, 1'b1, 65'h5);
        verdict_a("t7b", 1'b0, 9'd0, 32'h0);
        chk("t7_bad", 64'(a_bad), 64'd2);
        wd(1'b1, 1'b0, 65'h1);
        wd(1'b1, 1'b1, 65'h0);
        verdict_a("t7c", 1'b1, 9'd0, 32'h0);
        chk("t7c_frm", 64'(a_frm), 64'd3);
        chk("t7c_good", 64'(a_good), 64'd7);

        CNT_CLR = 1'b1;
        stall(1);
        CNT_CLR = 1'b0;
        chk("b_clr_good", 64'(b_good), 64'd0);
        chk("b_clr_frm", 64'(b_frm), 64'd0);
        wd(1'b1, 1'b0, 65'h0);
        repeat (3) wd(1'b0, 1'b0, 65'h0);
        wd(1'b0, 1'b1, 65'h0);
        chk("b_max_vld", 64'(b_vld), 64'd1);
        chk("b_max_len", 64'(b_len), 64'd4);
        chk("b_max_good", 64'(b_good), 64'd1);
        wd(1'b1, 1'b0, 65'h0);
        repeat (4) wd(1'b0, 1'b0, 65'h0);
        chk("b_ovf_frm", 64'(b_frm), 64'd1);
        wd(1'b0, 1'b1, 65'h0);
        chk("b_ovf_novld", 64'(b_vld), 64'd0);
        wd(1'b1, 1'b1, 65'h0);
        chk("b_idle_vld", 64'(b_vld), 64'd1);
        chk("b_idle_good", 64'(b_good), 64'd2);
        wd(1'b1, 1'b0, 65'h0);
        repeat (4) wd(1'b0, 1'b0, 65'h0);
        wd(1'b1, 1'b0, 65'h1);
        chk("b_drop_sof_frm", 64'(b_frm), 64'd2);
        wd(1'b0, 1'b1, 65'h00A00805);
        chk("b_drop_sof_pass", 64'(b_pass), 64'd1);
        chk("b_drop_sof_good", 64'(b_good), 64'd3);
        repeat (4) wd(1'b1, 1'b1, 65'h0);
        chk("b_sat_reach", 64'(b_good), 64'd7);
        repeat (2) wd(1'b1, 1'b1, 65'h0);
        chk("b_sat_hold", 64'(b_good), 64'd7);
        CNT_CLR = 1'b1;
        wd(1'b1, 1'b1, 65'h0);
        CNT_CLR = 1'b0;
        chk("clr_inc_vld", 64'(b_vld), 64'd1);
        chk("clr_inc_b", 64'(b_good), 64'd0);
        chk("clr_inc_a", 64'(a_good), 64'd0);

        wd(1'b1, 1'b0, 65'h1);
        #2 RST_N = 1'b0;
        #1;
        chk("mid_rst_vld", 64'(a_vld), 64'd0);
        chk("mid_rst_len", 64'(a_len), 64'd0);
        stall(1);
        RST_N = 1'b1;
        wd(1'b0, 1'b1, 65'h00A00805);
        chk("mid_rst_novld", 64'(a_vld), 64'd0);
        chk("mid_rst_frm", 64'(a_frm), 64'd1);
        chk("mid_rst_good", 64'(a_good), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crc32_galois_d65_chk.md
Name: crc32_galois_d65_chk

Overview:
Receive-side CRC checker for the 65-bit word stream protected by the CRC32 Galois generator (poly 1+x^2+x^11+x^21+x^23+x^32, seed 0).
- Accumulates CRC over the payload words of a frame.
- Compares the result against the CRC carried in the frame's final word.
- Reports pass/fail per frame and keeps saturating error statistics.
- Sits in the FC1 receive path after block alignment/descrambling, ahead of frame parsing.

Parameters:
MAX_WORDS, 256, maximum payload words per frame; the CRC word is not counted.
CNT_W, 16, width of the statistics counters.
LEN_W, 9, width of the payload word counter; must hold MAX_WORDS+1.

Ports:
CLK  input  1  clock
RST_N  input  1  asynchronous active-low reset
IN_VLD  input  1  DIN/IN_SOF/IN_EOF qualifier; low = stall, no state change
IN_SOF  input  1  first word of frame (payload, or CRC word if frame is empty)
IN_EOF  input  1  CRC word: DIN[31:0] = expected CRC, DIN[64:32] ignored
DIN  input  65  data word
CNT_CLR  input  1  synchronous clear of all statistics counters
RES_VLD  output  1  one-cycle pulse: frame verdict available
RES_PASS  output  1  1 = CRC matched; valid with RES_VLD
RES_LEN  output  LEN_W  payload words in the frame; valid with RES_VLD
RES_CRC  output  32  computed CRC; valid with RES_VLD
CNT_GOOD  output  CNT_W  frames passed, saturating
CNT_BAD  output  CNT_W  frames with CRC mismatch, saturating
CNT_FRM  output  CNT_W  framing/length errors, saturating

Behaviour:
- Reset (RST_N low, async): state IDLE, CRC accumulator 0, word count 0. All outputs 0. Counters 0.
- Next-state CRC function: identical to the generator's 65-bit parallel Galois equations (srd = f(srq, DIN)). The generator clears when its enable is low; the checker instead holds the accumulator on stalls.
- States:
  - IDLE: waiting for SOF.
  - ACCUM: inside a frame.
  - DROP: length overflow; discard until EOF.
- IDLE, IN_VLD & IN_SOF & !IN_EOF: acc <= f(0, DIN), count <= 1 -> ACCUM.
- IDLE, IN_VLD & IN_SOF & IN_EOF (empty frame): compare 0 against DIN[31:0]; verdict issued; stay IDLE.
- IDLE, IN_VLD & !IN_SOF: word discarded. If IN_EOF=1, CNT_FRM += 1.
- ACCUM, IN_VLD & !IN_SOF & !IN_EOF: acc <= f(acc, DIN), count += 1.
  - If count would exceed MAX_WORDS: CNT_FRM += 1 -> DROP, with no RES_VLD.
- ACCUM, IN_VLD & IN_EOF & !IN_SOF: compare acc with DIN[31:0]; verdict issued -> IDLE.
- ACCUM, IN_VLD & IN_SOF: current frame aborted with CNT_FRM += 1 and no RES_VLD. The new frame restarts exactly as from IDLE (SOF&EOF handled as an empty frame).
- DROP: ignore words until IN_VLD & IN_EOF -> IDLE. IN_VLD & IN_SOF in DROP restarts as from IDLE; no additional CNT_FRM.
- Verdict latency: RES_* registered, asserted the cycle after the CRC word is accepted. RES_VLD is a single-cycle pulse; back-to-back frames produce pulses on consecutive cycles where possible.
- RES_PASS = (computed == DIN[31:0]). RES_CRC = computed value. RES_LEN = payload word count (0 for an empty frame).
- CNT_GOOD / CNT_BAD increment in the same cycle as RES_VLD. All counters saturate at all-ones.
- CNT_CLR wins over a simultaneous increment: the counter becomes 0, not 1.
- IN_VLD low: everything holds, including mid-frame. Stalls of any length are legal.
- Reset asserted mid-frame: frame lost silently, no counter update.

Decomposition:
- Shared package crc32_galois_pkg:
  - CRC32_POLY constant (32'h00A00805, low-order taps incl. x^0).
  - CRC32_SEED = 32'h0.
  - State enum {IDLE, ACCUM, DROP}.
  - Function crc32_d65_next(crc[31:0], din[64:0]) holding the parallel equations, so the generator and checker share one source.
- One sub-module: crc32_sat_cnt (CNT_W saturating counter with clear and increment); instantiated three times.

Test Plan:
- Frame {SOF DIN=0}, {EOF DIN[31:0]=0x00000000} -> RES_VLD pulse 1 cycle after EOF; RES_PASS=1, RES_LEN=1, RES_CRC=0; CNT_GOOD=1.
- Frame {SOF DIN=65'h1}, {EOF DIN[31:0]=0x00A00805} -> PASS, RES_CRC=0x00A00805.
- Repeat with EOF DIN[31:0]=0x00A00804 -> RES_PASS=0, CNT_BAD=1.
- Frame {SOF DIN=65'h1_0000_0000_0000_0000}, then 5 idle stall cycles, then {EOF 0x30201181} -> PASS; result unaffected by the stall.
- Two SOF words with no EOF between, then EOF with the correct CRC of the second frame -> CNT_FRM=1, one RES_VLD with PASS. Lone EOF in IDLE -> CNT_FRM=2, no RES_VLD.
- MAX_WORDS=4, SOF plus 4 further payload words then EOF -> CNT_FRM=1, no RES_VLD, FSM back in IDLE. Preload a counter to 0xFFFF via traffic -> stays 0xFFFF. CNT_CLR coincident with an increment -> 0.
